// File: rtl/pc_redirect_arbiter.sv
// Buffers one JR redirect per SIC and offers the oldest one (wrap-aware issue-ID age) through a registered valid/ready output.
// Two-cycle pulse-to-offer latency; SIC capture never stalls, and younger work is squashed on accept or rollback.
module pc_redirect_arbiter #(
  parameter int NUM_SICS = 8,
  parameter int ID_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SICS-1:0]          sic_pc_redirect_valid,
  input  logic [NUM_SICS*32-1:0]       sic_pc_redirect_pc,
  input  logic [NUM_SICS*ID_WIDTH-1:0] sic_pc_redirect_issue_id,
  input  logic [ID_WIDTH-1:0]          oldest_issue_id,
  input  logic                         rollback_trigger,
  output logic                         redirect_valid,
  output logic [31:0]                  redirect_pc,
  output logic [ID_WIDTH-1:0]          redirect_issue_id,
  input  logic                         redirect_ready
);

  localparam int IDX_W = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  logic                r_slot_vld [NUM_SICS];
  logic [31:0]         r_slot_pc  [NUM_SICS];
  logic [ID_WIDTH-1:0] r_slot_id  [NUM_SICS];
  logic                r_out_vld;
  logic [31:0]         r_out_pc;
  logic [ID_WIDTH-1:0] r_out_id;

  logic [31:0]         w_in_pc      [NUM_SICS];
  logic [ID_WIDTH-1:0] w_in_id      [NUM_SICS];
  logic [ID_WIDTH-1:0] w_slot_age   [NUM_SICS];
  logic                w_slot_vld_nxt [NUM_SICS];
  logic [31:0]         w_slot_pc_nxt  [NUM_SICS];
  logic [ID_WIDTH-1:0] w_slot_id_nxt  [NUM_SICS];
  logic                w_win_vld;
  logic [IDX_W-1:0]    w_win_idx;
  logic [ID_WIDTH-1:0] w_win_age;
  logic [ID_WIDTH-1:0] w_out_age;
  logic                w_accept;
  logic                w_win_squash;
  logic                w_promote;

  function automatic logic [ID_WIDTH-1:0] f_age(input logic [ID_WIDTH-1:0] id,
                                                input logic [ID_WIDTH-1:0] base);
    return id - base;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SICS; i++) begin
      w_in_pc[i]    = sic_pc_redirect_pc[i*32 +: 32];
      w_in_id[i]    = sic_pc_redirect_issue_id[i*ID_WIDTH +: ID_WIDTH];
      w_slot_age[i] = f_age(r_slot_id[i], oldest_issue_id);
    end
  end

  // Strict compare keeps the lowest index on equal age.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_win_age = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      if (r_slot_vld[i] && (!w_win_vld || (w_slot_age[i] < w_win_age))) begin
        w_win_vld = 1'b1;
        w_win_idx = IDX_W'(i);
        w_win_age = w_slot_age[i];
      end
    end
  end

  assign w_out_age    = f_age(r_out_id, oldest_issue_id);
  assign w_accept     = r_out_vld && redirect_ready;
  // A winner no older than the accepted redirect is squashed, never promoted.
  assign w_win_squash = w_accept && (w_win_age >= w_out_age);
  assign w_promote    = w_win_vld && !rollback_trigger && !w_win_squash &&
                        (!r_out_vld || w_accept || (w_win_age < w_out_age));

  always_comb begin
    for (int i = 0; i < NUM_SICS; i++) begin
      w_slot_vld_nxt[i] = r_slot_vld[i] && !(w_promote && (w_win_idx == IDX_W'(i)));
      w_slot_pc_nxt[i]  = r_slot_pc[i];
      w_slot_id_nxt[i]  = r_slot_id[i];
      if (sic_pc_redirect_valid[i] &&
          (!w_slot_vld_nxt[i] || (f_age(w_in_id[i], oldest_issue_id) < w_slot_age[i]))) begin
        w_slot_vld_nxt[i] = 1'b1;
        w_slot_pc_nxt[i]  = w_in_pc[i];
        w_slot_id_nxt[i]  = w_in_id[i];
      end
      if (w_accept && (f_age(w_slot_id_nxt[i], oldest_issue_id) >= w_out_age)) begin
        w_slot_vld_nxt[i] = 1'b0;
      end
      if (rollback_trigger) begin
        w_slot_vld_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SICS; i++) begin
        r_slot_vld[i] <= 1'b0;
        r_slot_pc[i]  <= '0;
        r_slot_id[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SICS; i++) begin
        r_slot_vld[i] <= w_slot_vld_nxt[i];
        r_slot_pc[i]  <= w_slot_pc_nxt[i];
        r_slot_id[i]  <= w_slot_id_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_pc  <= '0;
      r_out_id  <= '0;
    end else if (rollback_trigger) begin
      r_out_vld <= 1'b0;
    end else if (w_promote) begin
      r_out_vld <= 1'b1;
      r_out_pc  <= r_slot_pc[w_win_idx];
      r_out_id  <= r_slot_id[w_win_idx];
    end else if (w_accept) begin
      r_out_vld <= 1'b0;
    end
  end

  assign redirect_valid    = r_out_vld;
  assign redirect_pc       = r_out_pc;
  assign redirect_issue_id = r_out_id;

endmodule

// File: tb/tb_pc_redirect_arbiter.sv
// Scoreboard bench: expected redirects are queued when pulses are driven and popped at each handshake.
module tb_pc_redirect_arbiter;

  localparam int N  = 8;
  localparam int IW = 16;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] id;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    sic_vld;
  logic [N*32-1:0] sic_pc;
  logic [N*IW-1:0] sic_id;
  logic [IW-1:0]   base;
  logic            rollback;
  logic            rd_vld;
  logic [31:0]     rd_pc;
  logic [IW-1:0]   rd_id;
  logic            rd_rdy;

  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  pc_redirect_arbiter #(.NUM_SICS(N), .ID_WIDTH(IW)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .sic_pc_redirect_valid    (sic_vld),
    .sic_pc_redirect_pc       (sic_pc),
    .sic_pc_redirect_issue_id (sic_id),
    .oldest_issue_id          (base),
    .rollback_trigger         (rollback),
    .redirect_valid           (rd_vld),
    .redirect_pc              (rd_pc),
    .redirect_issue_id        (rd_id),
    .redirect_ready           (rd_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    sic_vld  = '0;
    rollback = 1'b0;
  endtask

  task automatic pulse(input int s, input logic [31:0] pc, input logic [15:0] id);
    sic_vld[s]         = 1'b1;
    sic_pc[s*32 +: 32] = pc;
    sic_id[s*IW +: IW] = id;
  endtask

  task automatic expect_push(input logic [31:0] pc, input logic [15:0] id);
    exp_t e;
    e.pc = pc;
    e.id = id;
    sb_q.push_back(e);
  endtask

  task automatic accept(input string tag);
    exp_t e;
    chk({tag, "_vld"}, 64'(rd_vld), 64'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_has_entry"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pc"}, 64'(rd_pc), 64'(e.pc));
      chk({tag, "_id"}, 64'(rd_id), 64'(e.id));
    end
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      seen = seen | rd_vld;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    sic_vld  = '0;
    sic_pc   = '0;
    sic_id   = '0;
    base     = '0;
    rollback = 1'b0;
    rd_rdy   = 1'b0;

    #2;
    chk("reset_vld", 64'(rd_vld), 64'd0);
    chk("reset_pc",  64'(rd_pc),  64'd0);
    chk("reset_id",  64'(rd_id),  64'd0);
    #10 rst_n = 1'b1;
    tick();

    // Single redirect: two-cycle latency, hold under stall, drop after accept.
    pulse(3, 32'h3040, 16'd5);
    expect_push(32'h3040, 16'd5);
    tick();
    chk("single_lat1_vld", 64'(rd_vld), 64'd0);
    tick();
    chk("single_lat2_vld", 64'(rd_vld), 64'd1);
    tick();
    tick();
    chk("single_hold_id", 64'(rd_id), 64'd5);
    accept("single_acc");
    chk("single_drop_vld", 64'(rd_vld), 64'd0);

    // Oldest wins; the younger one is squashed by the accept.
    pulse(1, 32'h1111, 16'd9);
    pulse(6, 32'h6666, 16'd7);
    expect_push(32'h6666, 16'd7);
    tick();
    tick();
    accept("oldest_acc");
    chk("oldest_squash_vld", 64'(rd_vld), 64'd0);
    idle_check("oldest_no_late", 4);

    // Wrap-around: 0xFFFF is older than 0x0001 relative to base 0xFFFE.
    base = 16'hFFFE;
    pulse(0, 32'hA000, 16'h0001);
    pulse(2, 32'hA222, 16'hFFFF);
    expect_push(32'hA222, 16'hFFFF);
    tick();
    tick();
    accept("wrap_acc");
    idle_check("wrap_squash", 3);

    // Replace while stalled.
    base = 16'd0;
    pulse(5, 32'h2020, 16'd20);
    tick();
    tick();
    chk("replace_first_id", 64'(rd_id), 64'd20);
    tick();
    pulse(4, 32'h1212, 16'd12);
    expect_push(32'h1212, 16'd12);
    tick();
    chk("replace_still_old", 64'(rd_id), 64'd20);
    tick();
    chk("replace_new_id", 64'(rd_id), 64'd12);
    tick();
    accept("replace_acc");
    idle_check("replace_old_gone", 4);

    // Rollback with pending slots, an offered output and a same-cycle pulse.
    pulse(0, 32'h3030, 16'd30);
    tick();
    tick();
    chk("rb_offer_vld", 64'(rd_vld), 64'd1);
    pulse(1, 32'h4040, 16'd40);
    pulse(2, 32'h4141, 16'd41);
    pulse(3, 32'h4242, 16'd42);
    tick();
    chk("rb_offer_keep", 64'(rd_id), 64'd30);
    rollback = 1'b1;
    pulse(7, 32'h0707, 16'd1);
    tick();
    chk("rb_next_vld", 64'(rd_vld), 64'd0);
    idle_check("rb_never_again", 6);

    // Asynchronous reset off a clock edge.
    pulse(3, 32'h5050, 16'd50);
    tick();
    tick();
    chk("arst_pre_vld", 64'(rd_vld), 64'd1);
    #2;
    rst_n = 1'b0;
    pulse(2, 32'h6060, 16'd60);
    #1;
    chk("arst_vld", 64'(rd_vld), 64'd0);
    chk("arst_pc",  64'(rd_pc),  64'd0);
    chk("arst_id",  64'(rd_id),  64'd0);
    tick();
    #2 rst_n = 1'b1;
    idle_check("arst_pulse_lost", 4);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect_arbiter.md
# pc_redirect_arbiter

Collects JR PC-redirect feedback pulses from all single-instruction controllers and turns them into one registered redirect request for the issue controller. It is the receiving end of the per-SIC `pc_redirect_valid / pc_redirect_pc / pc_redirect_issue_id` interface. It buffers one pending redirect per SIC and always presents the oldest outstanding redirect, using wrap-aware issue-ID age. It discards redirects squashed by an older accepted redirect or by a rollback.

## Interface
- `NUM_SICS`, 8, number of SIC feedback ports.
- `ID_WIDTH`, 16, issue-ID width; IDs wrap modulo 2^ID_WIDTH.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sic_pc_redirect_valid[NUM_SICS]`  in  1 each  single-cycle redirect pulse from SIC i.
- `sic_pc_redirect_pc[NUM_SICS]`  in  32 each  redirect target, valid with the pulse.
- `sic_pc_redirect_issue_id[NUM_SICS]`  in  ID_WIDTH each  issue ID of the JR.
- `oldest_issue_id`  in  ID_WIDTH  age base: ID of the oldest in-flight instruction.
- `rollback_trigger`  in  1  flush everything.
- `redirect_valid`  out  1  a redirect is offered.
- `redirect_pc`  out  32  offered target.
- `redirect_issue_id`  out  ID_WIDTH  offered issue ID.
- `redirect_ready`  in  1  consumer accepts; the handshake completes at a rising edge with valid&ready.

## Operation
- Age: `age(x) = (x - oldest_issue_id) mod 2^ID_WIDTH`. A smaller age is older. On equal age, the lower SIC index wins.
- Storage: one slot per SIC holding `{valid, pc, id}`, plus one output register.
- Capture: a pulse on SIC i writes slot i when either condition holds:
  - the slot is empty, or
  - the new ID is older than the stored ID.
  Otherwise the pulse is ignored.
- Select: each cycle, combinationally pick the oldest valid slot (the winner).
- Promote: at an edge, the winner moves into the output register and its slot clears when either condition holds:
  - the output register is empty or being accepted, or
  - the winner is strictly older than the output contents.
  A displaced output entry is discarded, because it is younger and therefore squashed.
- Accept: on valid&ready with accepted ID A, clear every slot whose age is greater than or equal to age(A). This includes pulses captured at that same edge.
- Rollback: `rollback_trigger` high at an edge clears all slots and the output register. A pulse in the same cycle is dropped, and a promote in the same cycle is suppressed.
- Payload stability: the payload may change while valid is high and ready is low, but only to an older redirect. The consumer uses the values present at the handshake edge.
- State per slot:
  - EMPTY → FULL on capture.
  - FULL → EMPTY on promote, squash or rollback.
  - FULL → FULL on overwrite by an older ID.
- State of the output register:
  - IDLE → OFFER on promote.
  - OFFER → OFFER on replace.
  - OFFER → IDLE on accept with no promote, or on rollback.

## Timing
- Reset values:
  - `redirect_valid` = 0.
  - `redirect_pc` = 0.
  - `redirect_issue_id` = 0.
  - All slots empty.
- Latency: a pulse in cycle t is captured at edge t, the slot is visible in t+1, the output is loaded at edge t+1, and `redirect_valid` is high in cycle t+2. The minimum is 2 cycles.
- Back-to-back: with `redirect_ready` held high, one redirect can be accepted per cycle. The winner promoted at the accept edge is visible the following cycle.
- Full condition: all NUM_SICS slots full plus the output register is legal. No backpressure exists toward the SICs, and capture never stalls.
- Wrap-around: ages are computed modulo the ID width only, with no reliance on raw magnitude.
- Reset asserted mid-operation: all state clears immediately (asynchronously). Pulses during reset are lost.

## Test plan
- Single redirect:
  - Stimulus: SIC 3 pulses pc=0x3040, id=5, base=0.
  - Required: `redirect_valid` is high 2 cycles later with 0x3040/5 and holds until ready; it drops the cycle after accept.
- Oldest wins:
  - Stimulus: in the same cycle, SIC 1 pulses id=9 and SIC 6 pulses id=7 (base=0).
  - Required: the output offers id=7. After acceptance of id=7, id=9 is squashed and `redirect_valid` goes low.
- Wrap-around:
  - Stimulus: base=0xFFFE; SIC 0 pulses id=0x0001 and SIC 2 pulses id=0xFFFF.
  - Required: 0xFFFF is offered first.
- Replace while stalled:
  - Stimulus: output offers id=20 with ready low; then SIC 4 pulses id=12.
  - Required: the output changes to id=12 two cycles later and id=20 is discarded.
- Rollback:
  - Stimulus: three pending slots plus an offered output; rollback asserted for 1 cycle together with a new pulse.
  - Required: `redirect_valid` = 0 next cycle, and no redirect ever appears afterward.
- Async reset:
  - Stimulus: `rst_n` dropped mid-offer, off a clock edge.
  - Required: outputs go to 0 immediately, without waiting for a clock edge.
